// File: rtl/uart_cmd_counter.sv
`timescale 1ns/1ps
// Command-driven up/down counter feeding the four-digit FND display path.
// Pops ASCII commands from a first-word-fall-through RX FIFO and counts on a prescaled tick.
module uart_cmd_counter #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int TICK_HZ   = 10,
    parameter int MAX_COUNT = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_empty,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    output logic [13:0] o_counter,
    output logic        o_run,
    output logic        o_dir
);

    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int PW       = $clog2(TICK_DIV);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [13:0]   MAX_VAL    = 14'(MAX_COUNT);

    // Commands compared after folding to upper case (bit 5 cleared).
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_CLR  = 8'h43;
    localparam logic [7:0] CMD_UP   = 8'h55;
    localparam logic [7:0] CMD_DOWN = 8'h44;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        EXEC
    } state_t;

    state_t        state;
    logic [7:0]    cmd;
    logic [7:0]    cmd_uc;
    logic [PW-1:0] presc;
    logic          tick;
    logic          exec_clr;

    assign cmd_uc   = cmd & 8'hDF;
    assign exec_clr = (state == EXEC) && (cmd_uc == CMD_CLR);
    assign tick     = o_run && (presc == PRESC_LAST);

    // Command sequencer: IDLE -> POP -> EXEC, three cycles per byte. EXEC always
    // returns to IDLE, so rx_empty is never sampled in the cycle right after a pop.
    // NOTE: sequential state uses non-blocking (<=) so every register reads the
    // pre-edge value of its neighbours; blocking here would create order races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cmd    <= 8'h00;
            rx_pop <= 1'b0;
            o_run  <= 1'b0;
            o_dir  <= 1'b0;
        end else begin
            rx_pop <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_empty) begin
                        state  <= POP;
                        rx_pop <= 1'b1;
                    end
                end
                POP: begin
                    cmd   <= rx_data;
                    state <= EXEC;
                end
                EXEC: begin
                    state <= IDLE;
                    case (cmd_uc)
                        CMD_RUN:  o_run <= ~o_run;
                        CMD_UP:   o_dir <= 1'b0;
                        CMD_DOWN: o_dir <= 1'b1;
                        default:  ;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Prescaler and counter. A clear in EXEC overrides a coincident tick; a tick
    // coincident with a direction or run change still uses the pre-edge o_dir/o_run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc     <= '0;
            o_counter <= '0;
        end else if (exec_clr) begin
            presc     <= '0;
            o_counter <= '0;
        end else begin
            if (o_run) begin
                presc <= tick ? '0 : presc + PRESC_ONE;
            end
            if (tick) begin
                if (!o_dir) begin
                    o_counter <= (o_counter == MAX_VAL) ? 14'd0 : o_counter + 14'd1;
                end else begin
                    o_counter <= (o_counter == 14'd0) ? MAX_VAL : o_counter - 14'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_counter.sv
`timescale 1ns/1ps
// Self-checking bench for uart_cmd_counter: directed scenarios plus random command
// traffic, compared each cycle against a transaction-level reference model.
module tb_uart_cmd_counter;

    localparam int CLK_FREQ  = 100;
    localparam int TICK_HZ   = 10;
    localparam int MAX_COUNT = 12;
    localparam int TICK_DIV  = CLK_FREQ / TICK_HZ;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        rx_empty = 1'b1;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_pop;
    logic [13:0] o_counter;
    logic        o_run;
    logic        o_dir;

    uart_cmd_counter #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ),
        .MAX_COUNT(MAX_COUNT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_empty (rx_empty),
        .rx_data  (rx_data),
        .rx_pop   (rx_pop),
        .o_counter(o_counter),
        .o_run    (o_run),
        .o_dir    (o_dir)
    );

    always #5 clk = ~clk;

    int n_vec    = 0;
    int n_err    = 0;
    int pop_seen = 0;

    logic [7:0] fifo_q[$];

    // Reference model: run/dir flags, count, running-cycle phase, and the
    // position of the byte in flight within its 3-cycle command transaction
    // (0 = none, 1 = pop cycle, 2 = execute cycle).
    int         m_count;
    int         m_phase;
    bit         m_run;
    bit         m_dir;
    int         m_stage;
    logic [7:0] m_byte;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_count = 0;
        m_phase = 0;
        m_run   = 1'b0;
        m_dir   = 1'b0;
        m_stage = 0;
        m_byte  = 8'h00;
    endfunction

    // Advance the model across one rising edge, using the inputs of the cycle just ended.
    function automatic void model_step();
        int n_count = m_count;
        int n_phase = m_phase;
        bit n_run   = m_run;
        bit n_dir   = m_dir;
        bit tk      = m_run && (m_phase == TICK_DIV - 1);
        if (m_run) n_phase = (m_phase + 1) % TICK_DIV;
        if (tk) begin
            if (m_dir) n_count = (m_count + MAX_COUNT) % (MAX_COUNT + 1);
            else       n_count = (m_count + 1) % (MAX_COUNT + 1);
        end
        case (m_stage)
            0: if (!rx_empty) m_stage = 1;
            1: begin
                m_byte  = fifo_q.pop_front();
                m_stage = 2;
            end
            default: begin
                case (m_byte)
                    8'h52, 8'h72: n_run = !m_run;
                    8'h43, 8'h63: begin
                        n_count = 0;
                        n_phase = 0;
                    end
                    8'h55, 8'h75: n_dir = 1'b0;
                    8'h44, 8'h64: n_dir = 1'b1;
                    default: ;
                endcase
                m_stage = 0;
            end
        endcase
        m_count = n_count;
        m_phase = n_phase;
        m_run   = n_run;
        m_dir   = n_dir;
    endfunction

    task automatic drive();
        rx_empty = (fifo_q.size() == 0);
        rx_data  = rx_empty ? 8'($urandom) : fifo_q[0];
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        drive();
    endtask

    task automatic cycle();
        @(negedge clk);
        if (rst) model_reset();
        else     model_step();
        drive();
        if (rx_pop) pop_seen++;
        check("counter", o_counter, m_count);
        check("run", o_run, m_run);
        check("dir", o_dir, m_dir);
        check("pop", rx_pop, m_stage == 1);
    endtask

    logic [7:0] cmd_tbl[10] = '{8'h72, 8'h52, 8'h63, 8'h43, 8'h75, 8'h55, 8'h64, 8'h44, 8'h78, 8'h00};

    initial begin
        int n;
        model_reset();
        drive();
        repeat (3) cycle();
        rst = 1'b0;

        // Idle after reset with an empty FIFO.
        pop_seen = 0;
        repeat (50) cycle();
        check("t1_pops", pop_seen, 0);
        check("t1_counter", o_counter, 0);

        // Single 'r': run, three ticks ten cycles apart.
        pop_seen = 0;
        push(8'h72);
        repeat (35) cycle();
        check("t2_pops", pop_seen, 1);
        check("t2_counter", o_counter, 3);
        check("t2_run", o_run, 1);

        // Up wrap at MAX_COUNT, then 'd' at zero wraps down to MAX_COUNT.
        n = 0;
        while (m_count != MAX_COUNT && n < 400) begin cycle(); n++; end
        n = 0;
        while (m_count != 0 && n < 400) begin cycle(); n++; end
        check("t3_wait", (n < 400), 1);
        check("t3_wrap_up", o_counter, 0);
        push(8'h64);
        repeat (11) cycle();
        check("t3_wrap_down", o_counter, MAX_COUNT);

        // Stop, then five back-to-back bytes.
        push(8'h72);
        repeat (5) cycle();
        pop_seen = 0;
        push(8'h72); push(8'h78); push(8'h43); push(8'h75); push(8'h52);
        repeat (20) cycle();
        check("t4_pops", pop_seen, 5);
        check("t4_counter", o_counter, 0);
        check("t4_run", o_run, 0);
        check("t4_dir", o_dir, 0);

        // Clear whose EXEC edge coincides with a tick at count 7.
        push(8'h72);
        n = 0;
        while (!(m_count == 7 && m_phase == 7 && m_stage == 0) && n < 300) begin cycle(); n++; end
        check("t5_wait", (n < 300), 1);
        push(8'h63);
        repeat (3) cycle();
        check("t5_clear", o_counter, 0);
        repeat (9) cycle();
        check("t5_hold", o_counter, 0);
        cycle();
        check("t5_next", o_counter, 1);

        // Reset asserted in the POP cycle of an 'r' with the counter at 5.
        n = 0;
        while (!(m_count == 5 && m_phase == 0) && n < 300) begin cycle(); n++; end
        check("t6_wait", (n < 300), 1);
        push(8'h72);
        cycle();
        check("t6_pop_cycle", rx_pop, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_counter", o_counter, 0);
        check("t6_rst_run", o_run, 0);
        check("t6_rst_dir", o_dir, 0);
        check("t6_rst_pop", rx_pop, 0);
        void'(fifo_q.pop_front());
        model_reset();
        push(8'h64);
        cycle();
        cycle();
        rst = 1'b0;
        pop_seen = 0;
        repeat (8) cycle();
        check("t6_next_pop", pop_seen, 1);
        check("t6_run", o_run, 0);
        check("t6_dir", o_dir, 1);

        // Random command traffic.
        repeat (3000) begin
            if (fifo_q.size() < 3 && $urandom_range(0, 7) == 0) begin
                n = $urandom_range(0, 9);
                push(n == 9 ? 8'($urandom) : cmd_tbl[n]);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
